// File: rtl/key_command_pkg.sv
// key_command_pkg -- shared constants and types for the key_command block.
//   KEY_*      : raw USB keycodes recognised in either keycode slot
//   CMD_*      : movement commands presented on key_command.key
//   jump_state_t : jump arbitration FSM states
//   key_present(): true when either 8-bit slot of a keycode word matches
package key_command_pkg;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam logic [15:0] CMD_UP    = 16'h001A;
    localparam logic [15:0] CMD_LEFT  = 16'h0004;
    localparam logic [15:0] CMD_RIGHT = 16'h0007;
    localparam logic [15:0] CMD_NONE  = 16'h0000;

    // Debounce counter covers 1..15 frames, cooldown counter 1..63 frames.
    localparam int unsigned DB_CNT_W = 4;
    localparam int unsigned CD_CNT_W = 6;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        COOLDOWN = 2'd1,
        HELD     = 2'd2
    } jump_state_t;

    function automatic logic key_present(input logic [15:0] kc, input logic [7:0] code);
        return (kc[15:8] == code) || (kc[7:0] == code);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce -- frame-rate debounce for a single key.
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   tick_i     : frame tick; counter and accepted state change only here
//   raw_i      : raw presence of the key (from the registered keycode)
//   accepted_o : debounced key state
// The accepted state flips once raw presence has disagreed with it on
// DEBOUNCE_FRAMES consecutive ticks; an agreeing tick restarts the count.
module key_debounce
    import key_command_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic raw_i,
    output logic accepted_o
);

    localparam logic [DB_CNT_W-1:0] LIMIT = DB_CNT_W'(DEBOUNCE_FRAMES);

    logic [DB_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                acc_q, acc_d;

    assign cnt_inc = cnt_q + DB_CNT_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (tick_i) begin
            if (raw_i != acc_q) begin
                if (cnt_inc == LIMIT) begin
                    acc_d = raw_i;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign accepted_o = acc_q;

endmodule

// File: rtl/key_command.sv
// key_command -- turns raw USB keycodes into debounced movement commands
// and rate-limited jump requests for the ball stage.
//   Clk        : system clock
//   Reset      : asynchronous active-low reset
//   frame_tick : one-cycle pulse per video frame
//   keycode    : two raw keycode slots [15:8] and [7:0], 8'h00 = empty
//   key        : resolved command (CMD_UP / CMD_LEFT / CMD_RIGHT / CMD_NONE)
//   jump_req   : one-cycle pulse per accepted jump
//   left_held  : debounced A level
//   right_held : debounced D level
// Build option: define KEY_COMMAND_REPEAT_EN to auto-repeat jumps while W
// stays held; otherwise HELD blocks further jumps until W is released.
module key_command
    import key_command_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned JUMP_COOLDOWN   = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [15:0] keycode,
    output logic [15:0] key,
    output logic        jump_req,
    output logic        left_held,
    output logic        right_held
);

    localparam logic [CD_CNT_W-1:0] COOL_LOAD = CD_CNT_W'(JUMP_COOLDOWN);

    logic [15:0]         keycode_q;
    logic                acc_w, acc_a, acc_d;
    logic                w_prev_q;
    logic                rise_w;
    jump_state_t         state_q, state_d;
    logic [CD_CNT_W-1:0] cool_q, cool_d;
    logic                jump_req_q, jump_req_d;
    logic                window_q, window_d;
    logic [15:0]         key_q, key_d;
    logic                left_q, right_q;

    key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_w (
        .clk_i(Clk), .rst_ni(Reset), .tick_i(frame_tick),
        .raw_i(key_present(keycode_q, KEY_W)), .accepted_o(acc_w)
    );
    key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_a (
        .clk_i(Clk), .rst_ni(Reset), .tick_i(frame_tick),
        .raw_i(key_present(keycode_q, KEY_A)), .accepted_o(acc_a)
    );
    key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_d (
        .clk_i(Clk), .rst_ni(Reset), .tick_i(frame_tick),
        .raw_i(key_present(keycode_q, KEY_D)), .accepted_o(acc_d)
    );

    // Rising edge of accepted W, seen the cycle after the debounce flips.
    assign rise_w = acc_w & ~w_prev_q;

    always_comb begin
        state_d    = state_q;
        cool_d     = cool_q;
        jump_req_d = 1'b0;
        window_d   = window_q;

        // A tick landing in the jump_req cycle itself must not close the window.
        if (frame_tick && !jump_req_q) begin
            window_d = 1'b0;
        end

        case (state_q)
            READY: begin
                if (rise_w) begin
                    state_d    = COOLDOWN;
                    cool_d     = COOL_LOAD;
                    jump_req_d = 1'b1;
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    cool_d = cool_q - CD_CNT_W'(1);
                    if (cool_q <= CD_CNT_W'(1)) begin
                        cool_d = '0;
`ifdef KEY_COMMAND_REPEAT_EN
                        if (acc_w) begin
                            cool_d     = COOL_LOAD;
                            jump_req_d = 1'b1;
                        end else begin
                            state_d = READY;
                        end
`else
                        state_d = acc_w ? HELD : READY;
`endif
                    end
                end
            end
            HELD: begin
                if (!acc_w) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = READY;
                cool_d  = '0;
            end
        endcase

        if (jump_req_d) begin
            window_d = 1'b1;
        end

        key_d = CMD_NONE;
        if (window_q) begin
            key_d = CMD_UP;
        end else if (acc_a ^ acc_d) begin
            key_d = acc_a ? CMD_LEFT : CMD_RIGHT;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            keycode_q  <= '0;
            w_prev_q   <= 1'b0;
            state_q    <= READY;
            cool_q     <= '0;
            jump_req_q <= 1'b0;
            window_q   <= 1'b0;
            key_q      <= CMD_NONE;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
        end else begin
            keycode_q  <= keycode;
            w_prev_q   <= acc_w;
            state_q    <= state_d;
            cool_q     <= cool_d;
            jump_req_q <= jump_req_d;
            window_q   <= window_d;
            key_q      <= key_d;
            left_q     <= acc_a;
            right_q    <= acc_d;
        end
    end

    assign key        = key_q;
    assign jump_req   = jump_req_q;
    assign left_held  = left_q;
    assign right_held = right_q;

endmodule
